serial_adder: RTL and testbench

//   Bit-serial W-bit unsigned adder built from two half-adder cells and a carry flip-flop.

---
 rtl/serial_adder_pkg.sv | 22 ++
 rtl/serial_adder_ha.sv | 12 +
 rtl/serial_adder.sv | 129 ++++++++++++
 tb/tb_serial_adder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

  // Controller states: waiting, shifting bits, result presented.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default operand width.
  localparam int W_DEFAULT = 8;

  // The bit counter has to reach W-1 and still fit the value W.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Counter width for the default operand width.
  localparam int CNT_W = cnt_width(W_DEFAULT);

endpackage

// File: rtl/serial_adder_ha.sv
// Half-adder bit slice: sum and carry of two single bits, purely combinational.
module ha_cell (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit unsigned adder. Operands are captured on an accepted start,
// summed LSB-first one bit per clock through two half-adder cells and a carry
// flip-flop, and the W+1 bit result is presented with a one-cycle done pulse.
//
// Handshake: start is a request sampled only in IDLE or DONE; the edge that
// samples it high is the accept edge. While busy is high any start is ignored
// and not remembered. done pulses for exactly one cycle and sum is valid in
// that cycle; sum then holds until the next accept edge.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W:0]   sum,
  output logic         bit_out,
  output logic         bit_vld,
  output logic [1:0]   state_dbg
);

  localparam int CNT_BITS = cnt_width(W);
  localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(W - 1);

  state_t              state_q;
  logic [W-1:0]        a_sh_q;
  logic [W-1:0]        b_sh_q;
  logic                carry_q;
  logic [CNT_BITS-1:0] count_q;
  logic [W:0]          sum_q;
  logic                busy_q;
  logic                done_q;
  logic                bit_out_q;
  logic                bit_vld_q;

  logic                ha0_s;
  logic                ha0_c;
  logic                bit_s;
  logic                ha1_c;
  logic                carry_d;
  logic [W-1:0]        sum_bits_d;

  // First slice adds the two operand bits, second folds in the stored carry.
  ha_cell u_ha0 (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .s_o (ha0_s),
    .c_o (ha0_c)
  );

  ha_cell u_ha1 (
    .a_i (ha0_s),
    .b_i (carry_q),
    .s_o (bit_s),
    .c_o (ha1_c)
  );

  // At most one of the two half-adder carries can be set, so OR is the full-adder carry.
  assign carry_d = ha0_c | ha1_c;

  // New sum bit enters from the MSB side so bit 0 ends up at the LSB after W steps.
  assign sum_bits_d = W'({bit_s, sum_q[W-1:0]} >> 1);

  // Controller and datapath registers; every output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      carry_q   <= 1'b0;
      count_q   <= '0;
      sum_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bit_out_q <= 1'b0;
      bit_vld_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      bit_vld_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= 1'b0;
            count_q <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_sh_q          <= a_sh_q >> 1;
          b_sh_q          <= b_sh_q >> 1;
          carry_q         <= carry_d;
          sum_q[W-1:0]    <= sum_bits_d;
          bit_out_q       <= bit_s;
          bit_vld_q       <= 1'b1;
          count_q         <= count_q + CNT_BITS'(1);
          if (count_q == LAST_BIT) begin
            sum_q[W] <= carry_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign bit_out   = bit_out_q;
  assign bit_vld   = bit_vld_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at W=8 and W=1. Expected results come
// from plain integer addition of the operands; expected serial bits are the
// bits of that sum, LSB first.
module tb_serial_adder;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT, W=8 ----------------
  logic       start8;
  logic [7:0] a8, b8;
  logic       busy8, done8, bit_out8, bit_vld8;
  logic [8:0] sum8;
  logic [1:0] state8;

  serial_adder #(.W(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .start     (start8),
    .a         (a8),
    .b         (b8),
    .busy      (busy8),
    .done      (done8),
    .sum       (sum8),
    .bit_out   (bit_out8),
    .bit_vld   (bit_vld8),
    .state_dbg (state8)
  );

  // ---------------- DUT, W=1 ----------------
  logic       start1;
  logic [0:0] a1, b1;
  logic       busy1, done1, bit_out1, bit_vld1;
  logic [1:0] sum1;
  logic [1:0] state1;

  serial_adder #(.W(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
    .a         (a1),
    .b         (b1),
    .busy      (busy1),
    .done      (done1),
    .sum       (sum1),
    .bit_out   (bit_out1),
    .bit_vld   (bit_vld1),
    .state_dbg (state1)
  );

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  int checks;
  int failures;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver: one W=8 operation ----------------
  // Observation cycle k is the cycle after the k-th rising edge following the
  // accept edge minus one, i.e. k=1 is the cycle right after acceptance.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input bit scramble);
    logic [8:0] exp_s;
    logic [8:0] sum_at_done;
    logic [7:0] bits;
    int nb, busy_n, done_n, done_at;
    exp_q.push_back({1'b0, av} + {1'b0, bv});
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    bits = '0; nb = 0; busy_n = 0; done_n = 0; done_at = -1; sum_at_done = '0;
    for (int k = 1; k <= 12; k++) begin
      if (busy8) busy_n++;
      if (bit_vld8) begin
        if (nb < 8) bits[nb] = bit_out8;
        nb++;
      end
      if (done8) begin
        done_n++;
        done_at = k;
        sum_at_done = sum8;
      end
      if (scramble) begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
      end
      @(negedge clk);
    end
    exp_s = exp_q.pop_front();
    check("sum_at_done", 32'(sum_at_done), 32'(exp_s));
    check("bit_stream", 32'(bits), 32'(exp_s[7:0]));
    check("bit_vld_count", 32'(nb), 32'd8);
    check("busy_cycles", 32'(busy_n), 32'd8);
    check("done_count", 32'(done_n), 32'd1);
    check("done_latency", 32'(done_at), 32'd9);
    check("sum_held_idle", 32'(sum8), 32'(exp_s));
    check("idle_state", 32'(state8), 32'd0);
  endtask

  // ---------------- driver: one W=1 operation ----------------
  task automatic op1(input logic av, input logic bv);
    logic [1:0] exp_s;
    exp_s = {1'b0, av} + {1'b0, bv};
    @(negedge clk);
    a1 = av; b1 = bv; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("w1_busy", 32'(busy1), 32'd1);
    check("w1_no_early_done", 32'(done1), 32'd0);
    @(negedge clk);
    check("w1_done", 32'(done1), 32'd1);
    check("w1_sum", 32'(sum1), 32'(exp_s));
    check("w1_bit_vld", 32'(bit_vld1), 32'd1);
    check("w1_bit_out", 32'(bit_out1), 32'(exp_s[0]));
    check("w1_busy_low", 32'(busy1), 32'd0);
    @(negedge clk);
    check("w1_done_pulse", 32'(done1), 32'd0);
    check("w1_sum_held", 32'(sum1), 32'(exp_s));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [8:0] sum_first;
    logic [8:0] sum_second;
    int done_n;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_sum", 32'(sum8), 32'd0);
    check("rst_bit_out", 32'(bit_out8), 32'd0);
    check("rst_bit_vld", 32'(bit_vld8), 32'd0);
    check("rst_state", 32'(state8), 32'd0);
    check("rst_w1_sum", 32'(sum1), 32'd0);

    // Directed operations
    op8(8'hFF, 8'h01, 1'b0);
    op8(8'hA5, 8'h5A, 1'b0);
    op8(8'h00, 8'h00, 1'b1);
    op8(8'hFF, 8'hFF, 1'b0);

    // Random operations, with operand scrambling during RUN on some
    for (int i = 0; i < 8; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    // start held high through an operation: in-flight op unaffected,
    // then accepted again on the done cycle.
    @(negedge clk);
    a8 = 8'h03; b8 = 8'h05; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'hF0; b8 = 8'h0F;
    repeat (8) @(negedge clk);
    check("held_done", 32'(done8), 32'd1);
    check("held_sum_first", 32'(sum8), 32'h008);
    @(negedge clk);
    check("held_rebusy", 32'(busy8), 32'd1);
    check("held_done_pulse", 32'(done8), 32'd0);
    check("held_state_run", 32'(state8), 32'd1);
    start8 = 1'b0;
    sum_first = 9'h008;
    sum_second = '0;
    done_n = 0;
    for (int j = 0; j < 12; j++) begin
      if (done8) begin
        done_n++;
        sum_second = sum8;
      end
      @(negedge clk);
    end
    check("held_second_done", 32'(done_n), 32'd1);
    check("held_sum_second", 32'(sum_second), 32'({1'b0, 8'hF0} + {1'b0, 8'h0F}));
    check("held_first_differs", 32'(sum_second == sum_first), 32'd0);

    // Asynchronous reset after four bit steps
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy_before", 32'(busy8), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy8), 32'd0);
    check("arst_done", 32'(done8), 32'd0);
    check("arst_sum", 32'(sum8), 32'd0);
    check("arst_bit_vld", 32'(bit_vld8), 32'd0);
    check("arst_state", 32'(state8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_n = 0;
    for (int j = 0; j < 12; j++) begin
      if (done8 || busy8) done_n++;
      @(negedge clk);
    end
    check("arst_no_activity", 32'(done_n), 32'd0);
    check("arst_sum_after", 32'(sum8), 32'd0);

    // Normal operation resumes after reset
    op8(8'h80, 8'h80, 1'b0);

    // W=1 corner cases
    op1(1'b1, 1'b1);
    op1(1'b1, 1'b0);
    op1(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
